// File: rtl/sr_pulse_ctrl.sv
// -----------------------------------------------------------------------------
// sr_pulse_ctrl
//
// Drives a gated SR latch with a timed set/reset pulse, then checks the
// latch's Q / Q_prim feedback and reports completion and errors.
//
// Command sequence per accepted command:
//   IDLE -> PULSE (PULSE_W cycles, G=1 with S/R from the captured command)
//        -> SETTLE (SETTLE_W cycles, all drives low)
//        -> CHECK (1 cycle, DONE=1, ERR=1 if feedback disagrees)
//        -> GUARD (GUARD_W cycles, skipped when GUARD_W=0)
//        -> IDLE
//
// Parameters:
//   PULSE_W   cycles S/R and G are held per command    (1..255)
//   SETTLE_W  idle cycles between pulse and check       (1..255)
//   GUARD_W   dead cycles after check before next accept (0..255)
//
// Ports:
//   CLK        sole clock, rising edge
//   RST_N      asynchronous active-low reset
//   CMD_VALID  command request
//   CMD_SET    command value (1 = set latch, 0 = reset latch), captured at accept
//   CMD_READY  high only in IDLE; accept = CMD_VALID & CMD_READY
//   S, R, G    set / reset / enable drives to the gated SR latch
//   Q_FB       latch Q feedback
//   QP_FB      latch Q_prim feedback
//   DONE       one-cycle completion pulse (CHECK cycle)
//   ERR        one-cycle failure pulse, coincident with DONE
//   EXP_Q      last successfully verified latch value
//   ERR_CNT    saturating count of failed checks
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module sr_pulse_ctrl #(
  parameter int unsigned PULSE_W  = 2,
  parameter int unsigned SETTLE_W = 1,
  parameter int unsigned GUARD_W  = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CMD_VALID,
  input  logic       CMD_SET,
  output logic       CMD_READY,
  output logic       S,
  output logic       R,
  output logic       G,
  input  logic       Q_FB,
  input  logic       QP_FB,
  output logic       DONE,
  output logic       ERR,
  output logic       EXP_Q,
  output logic [7:0] ERR_CNT
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_SETTLE,
    ST_CHECK,
    ST_GUARD
  } state_t;

  localparam logic [7:0] PULSE_LAST  = 8'(PULSE_W - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_W - 1);
  localparam logic [7:0] GUARD_LAST  = (GUARD_W == 0) ? 8'd0 : 8'(GUARD_W - 1);
  localparam logic       NO_GUARD    = (GUARD_W == 0);

  state_t     state, nxt;
  logic [7:0] cnt, cnt_n;
  logic       cap, cap_n;
  logic       pass_q, pass_n;
  logic       chk_pass;

  logic       ready_n, s_n, r_n, g_n, done_n, err_n, expq_n;
  logic [7:0] errcnt_n;

  // Equal Q/Q_prim can never satisfy both terms, so it always fails.
  assign chk_pass = (Q_FB == cap) && (QP_FB == ~cap);

  always_comb begin
    nxt      = state;
    cnt_n    = cnt + 8'd1;
    cap_n    = cap;
    pass_n   = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    expq_n   = EXP_Q;
    errcnt_n = ERR_CNT;

    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (CMD_READY && CMD_VALID) begin
          nxt   = ST_PULSE;
          cap_n = CMD_SET;
        end
      end
      ST_PULSE: begin
        if (cnt == PULSE_LAST) begin
          nxt   = ST_SETTLE;
          cnt_n = '0;
        end
      end
      ST_SETTLE: begin
        // Feedback is registered on the edge that enters CHECK, so DONE/ERR
        // appear as registered outputs during the CHECK cycle itself.
        if (cnt == SETTLE_LAST) begin
          nxt    = ST_CHECK;
          cnt_n  = '0;
          done_n = 1'b1;
          err_n  = ~chk_pass;
          pass_n = chk_pass;
          if (!chk_pass && (ERR_CNT != '1)) begin
            errcnt_n = ERR_CNT + 8'd1;
          end
        end
      end
      ST_CHECK: begin
        cnt_n = '0;
        nxt   = NO_GUARD ? ST_IDLE : ST_GUARD;
        if (pass_q) begin
          expq_n = cap;
        end
      end
      ST_GUARD: begin
        if (cnt == GUARD_LAST) begin
          nxt   = ST_IDLE;
          cnt_n = '0;
        end
      end
      default: begin
        nxt   = ST_IDLE;
        cnt_n = '0;
      end
    endcase

    // Drives derive from the next state, so S and R are mutually exclusive
    // by construction and fall together with G when PULSE is left.
    g_n     = (nxt == ST_PULSE);
    s_n     = g_n & cap_n;
    r_n     = g_n & ~cap_n;
    ready_n = (nxt == ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cap       <= 1'b0;
      pass_q    <= 1'b0;
      CMD_READY <= 1'b0;
      S         <= 1'b0;
      R         <= 1'b0;
      G         <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      EXP_Q     <= 1'b0;
      ERR_CNT   <= '0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_n;
      cap       <= cap_n;
      pass_q    <= pass_n;
      CMD_READY <= ready_n;
      S         <= s_n;
      R         <= r_n;
      G         <= g_n;
      DONE      <= done_n;
      ERR       <= err_n;
      EXP_Q     <= expq_n;
      ERR_CNT   <= errcnt_n;
    end
  end

endmodule

// File: tb/tb_sr_pulse_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sr_pulse_ctrl
//
// Two instances: u0 with default timing (PULSE_W=2, SETTLE_W=1, GUARD_W=1)
// and u1 with PULSE_W=1, SETTLE_W=1, GUARD_W=0. Each command's expected
// output timeline is computed from cycle offsets after accept; the latch
// feedback is supplied by the bench (correct or faulty) and is randomised
// outside the window in which the controller is allowed to look at it.
// -----------------------------------------------------------------------------
module tb_sr_pulse_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [1:0] vld, cset, qfb, qpfb;
  logic [1:0] rdy, s, r, g, done, err, expq;
  logic [1:0][7:0] ecnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference state: last verified value and error count per instance.
  logic [1:0] m_expq;
  int         m_ecnt [2];

  int pw [2] = '{2, 1};
  int sw [2] = '{1, 1};
  int gw [2] = '{1, 0};

  always #5 CLK = ~CLK;

  sr_pulse_ctrl #(.PULSE_W(2), .SETTLE_W(1), .GUARD_W(1)) u0 (
    .CLK(CLK), .RST_N(RST_N), .CMD_VALID(vld[0]), .CMD_SET(cset[0]),
    .CMD_READY(rdy[0]), .S(s[0]), .R(r[0]), .G(g[0]),
    .Q_FB(qfb[0]), .QP_FB(qpfb[0]), .DONE(done[0]), .ERR(err[0]),
    .EXP_Q(expq[0]), .ERR_CNT(ecnt[0])
  );

  sr_pulse_ctrl #(.PULSE_W(1), .SETTLE_W(1), .GUARD_W(0)) u1 (
    .CLK(CLK), .RST_N(RST_N), .CMD_VALID(vld[1]), .CMD_SET(cset[1]),
    .CMD_READY(rdy[1]), .S(s[1]), .R(r[1]), .G(g[1]),
    .Q_FB(qfb[1]), .QP_FB(qpfb[1]), .DONE(done[1]), .ERR(err[1]),
    .EXP_Q(expq[1]), .ERR_CNT(ecnt[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] outs(input int u);
    return {rdy[u], s[u], r[u], g[u], done[u], err[u], expq[u]};
  endfunction

  // mode: 0 = latch follows command, 1 = Q=QP=1, 2 = Q=QP=0, 3 = inverted value
  task automatic run_cmd(input int u, input logic cs, input int mode, input bit hold);
    int         to;
    int         chk_k, total;
    logic       fq, fqp;
    bit         fail;
    logic       eg, es, er, ed, ee, eq;
    logic [6:0] expv;
    int         new_cnt;

    chk_k = pw[u] + sw[u] + 1;
    total = chk_k + gw[u] + 1;
    case (mode)
      0:       begin fq = cs;  fqp = ~cs; end
      1:       begin fq = 1'b1; fqp = 1'b1; end
      2:       begin fq = 1'b0; fqp = 1'b0; end
      default: begin fq = ~cs; fqp = cs;  end
    endcase
    fail    = (mode != 0);
    new_cnt = fail ? ((m_ecnt[u] < 255) ? m_ecnt[u] + 1 : 255) : m_ecnt[u];

    to = 0;
    while (!rdy[u] && to < 50) begin
      @(posedge CLK); #1;
      to++;
    end
    check($sformatf("u%0d ready_wait", u), 32'(rdy[u]), 32'd1);

    vld[u]  = 1'b1;
    cset[u] = cs;
    qfb[u]  = 1'($urandom & 1);
    qpfb[u] = 1'($urandom & 1);

    for (int k = 1; k <= total; k++) begin
      @(posedge CLK); #1;

      eg   = (k <= pw[u]);
      es   = eg & cs;
      er   = eg & ~cs;
      ed   = (k == chk_k);
      ee   = ed & fail;
      eq   = (k > chk_k && !fail) ? cs : m_expq[u];
      expv = {(k == total), es, er, eg, ed, ee, eq};
      check($sformatf("u%0d cmd%0b k%0d {rdy,s,r,g,done,err,expq}", u, cs, k),
            32'(outs(u)), 32'(expv));
      if (k < chk_k)
        check($sformatf("u%0d k%0d err_cnt", u, k), 32'(ecnt[u]), 32'(m_ecnt[u]));
      else if (k > chk_k)
        check($sformatf("u%0d k%0d err_cnt", u, k), 32'(ecnt[u]), 32'(new_cnt));

      // Commands presented while busy must be ignored.
      if (k < total) begin
        vld[u]  = hold ? 1'b1 : 1'($urandom & 1);
        cset[u] = 1'($urandom & 1);
      end else begin
        vld[u]  = hold;
      end
      // Feedback only matters in the window leading into the check.
      if (k >= pw[u] && k < chk_k) begin
        qfb[u]  = fq;
        qpfb[u] = fqp;
      end else begin
        qfb[u]  = 1'($urandom & 1);
        qpfb[u] = 1'($urandom & 1);
      end
    end

    if (!fail) m_expq[u] = cs;
    m_ecnt[u] = new_cnt;
  endtask

  task automatic check_reset_outs(input string tag);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("%s u%0d outs", tag, u), 32'(outs(u)), 32'd0);
      check($sformatf("%s u%0d err_cnt", tag, u), 32'(ecnt[u]), 32'd0);
    end
  endtask

  initial begin
    vld    = '0;
    cset   = '0;
    qfb    = '0;
    qpfb   = '0;
    m_expq = '0;
    m_ecnt = '{0, 0};

    // Power-on reset
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outs("por");
    RST_N = 1'b1;
    #1;
    check("ready_before_edge", 32'(rdy), 32'd0);
    @(posedge CLK); #1;
    check("ready_after_release", 32'(rdy), 32'd3);

    // Basic set with a correct latch, then back-to-back set/reset with VALID held
    run_cmd(0, 1'b1, 0, 1'b0);
    run_cmd(0, 1'b1, 0, 1'b1);
    run_cmd(0, 1'b0, 0, 1'b1);
    vld[0] = 1'b0;

    // Forced Q=QP=1 on a set command: error, EXP_Q stays 0
    run_cmd(0, 1'b1, 1, 1'b0);

    // Repeated command equal to the verified value is still executed
    run_cmd(0, m_expq[0], 0, 1'b0);
    run_cmd(0, m_expq[0], 0, 1'b0);

    // Randomised traffic on both instances
    for (int i = 0; i < 40; i++)
      run_cmd(0, 1'($urandom & 1), (($urandom & 1) != 0) ? 0 : int'($urandom_range(1, 3)),
              1'($urandom & 1));
    vld[0] = 1'b0;
    for (int i = 0; i < 40; i++)
      run_cmd(1, 1'($urandom & 1), (($urandom & 1) != 0) ? 0 : int'($urandom_range(1, 3)),
              1'($urandom & 1));
    vld[1] = 1'b0;

    // Error counter saturation
    for (int i = 0; i < 300; i++)
      run_cmd(1, 1'($urandom & 1), int'($urandom_range(1, 3)), 1'b0);
    check("u1 err_cnt_saturated", 32'(ecnt[1]), 32'd255);

    // Reset in the first PULSE cycle
    run_cmd(0, 1'b1, 0, 1'b0);
    vld[0]  = 1'b1;
    cset[0] = 1'b1;
    @(posedge CLK); #1;
    check("pre_reset_g", 32'(g[0]), 32'd1);
    vld[0] = 1'b0;
    RST_N  = 1'b0;
    #1;
    check_reset_outs("mid_pulse_rst");
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      check($sformatf("held_rst c%0d", i), 32'({outs(0), outs(1)}), 32'd0);
    end
    RST_N = 1'b1;
    m_expq = '0;
    m_ecnt = '{0, 0};
    #1;
    check("rst_release_ready_low", 32'(rdy), 32'd0);
    @(posedge CLK); #1;
    check("rst_release_ready_high", 32'(rdy), 32'd3);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check($sformatf("post_rst_no_done c%0d", i), 32'(done), 32'd0);
    end
    run_cmd(0, 1'b0, 0, 1'b0);
    run_cmd(1, 1'b1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound in case a wait misbehaves.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
